difftest_int_wb_collector: RTL and testbench

Upstream feeder for the difftest integer-writeback probe. Captures up to two committed integer register writebacks per cycle from the core's commit stage, in program order. Buffers them in a FIFO and drains exactly one record per cycle into the single-port probe interface (valid/dest/data plus coreid). The probe has no backpressure, so this block absorbs dual-commit bursts and flags any loss.

---
 rtl/difftest_int_wb_collector.sv | 150 +++++++++++++++
 tb/tb_difftest_int_wb_collector.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/difftest_int_wb_collector.sv
// difftest_int_wb_collector
//
// Collects up to two committed integer register writebacks per cycle from the
// commit stage (slot 0 older, slot 1 younger), buffers them in a small FIFO and
// drains one record per cycle onto the single-port difftest probe. The probe
// cannot stall, so dual-commit bursts are absorbed here. Writebacks arriving
// while fewer than two entries are free are dropped and accounted for.
//
// Ports:
//   io_clock, io_reset          clock, async active-high reset
//   io_in0_* / io_in1_*         commit-slot writebacks (valid, 5-bit dest, 64-bit data)
//   io_in_ready                 >= 2 free FIFO entries (from registered count)
//   io_coreid                   constant core identifier
//   io_valid/io_dest/io_data    registered probe record
//   io_overflow                 sticky flag: some writeback was dropped
//   io_drop_cnt                 saturating count of dropped writebacks

module difftest_int_wb_collector #(
    parameter int           DEPTH   = 8,
    parameter logic [7:0]   COREID  = 8'd0,
    parameter bit           SKIP_X0 = 1'b1
) (
    input  logic        io_clock,
    input  logic        io_reset,
    input  logic        io_in0_valid,
    input  logic [4:0]  io_in0_dest,
    input  logic [63:0] io_in0_data,
    input  logic        io_in1_valid,
    input  logic [4:0]  io_in1_dest,
    input  logic [63:0] io_in1_data,
    output logic        io_in_ready,
    output logic [7:0]  io_coreid,
    output logic        io_valid,
    output logic [31:0] io_dest,
    output logic [63:0] io_data,
    output logic        io_overflow,
    output logic [15:0] io_drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    mem_dest [DEPTH];
    logic [63:0]   mem_data [DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q, valid_d;
    logic [31:0]   dest_q, dest_d;
    logic [63:0]   data_q, data_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;

    logic          req0, req1;
    logic          in_ready;
    logic [CW-1:0] free_cnt;
    logic [1:0]    n_req;
    logic [1:0]    n_enq;
    logic          deq;
    logic          wa_en, wb_en;
    logic [AW-1:0] wb_idx;
    logic [4:0]    wa_dest;
    logic [63:0]   wa_data;
    logic [16:0]   drop_sum;

    always_comb begin
        req0 = io_in0_valid && !(SKIP_X0 && (io_in0_dest == 5'd0));
        req1 = io_in1_valid && !(SKIP_X0 && (io_in1_dest == 5'd0));
        n_req = {1'b0, req0} + {1'b0, req1};

        free_cnt = CW'(DEPTH) - count_q;
        in_ready = (free_cnt >= CW'(2));

        n_enq = in_ready ? n_req : 2'd0;
        deq   = (count_q != '0);

        // Port A always takes the oldest requester; port B only carries slot 1
        // when both slots request, so program order is kept in the FIFO.
        wa_en   = in_ready && (req0 || req1);
        wa_dest = req0 ? io_in0_dest : io_in1_dest;
        wa_data = req0 ? io_in0_data : io_in1_data;
        wb_en   = in_ready && req0 && req1;
        wb_idx  = tail_q + AW'(1);

        head_d  = head_q + AW'(deq);
        tail_d  = tail_q + AW'(n_enq);
        // Ready guarantees >= 2 free entries, so this never exceeds DEPTH.
        count_d = count_q + CW'(n_enq) - CW'(deq);

        valid_d = deq;
        dest_d  = dest_q;
        data_d  = data_q;
        if (deq) begin
            dest_d = {27'd0, mem_dest[head_q]};
            data_d = mem_data[head_q];
        end

        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        drop_sum   = {1'b0, drop_cnt_q};
        if (!in_ready && (n_req != 2'd0)) begin
            overflow_d = 1'b1;
            drop_sum   = {1'b0, drop_cnt_q} + 17'(n_req);
            drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    always_ff @(posedge io_clock) begin
        if (wa_en) begin
            mem_dest[tail_q] <= wa_dest;
            mem_data[tail_q] <= wa_data;
        end
        if (wb_en) begin
            mem_dest[wb_idx] <= io_in1_dest;
            mem_data[wb_idx] <= io_in1_data;
        end
    end

    always_ff @(posedge io_clock or posedge io_reset) begin
        if (io_reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            dest_q     <= '0;
            data_q     <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            dest_q     <= dest_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign io_in_ready = in_ready;
    assign io_coreid   = COREID;
    assign io_valid    = valid_q;
    assign io_dest     = dest_q;
    assign io_data     = data_q;
    assign io_overflow = overflow_q;
    assign io_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_difftest_int_wb_collector.sv
// Testbench for difftest_int_wb_collector (default parameters: DEPTH=8,
// COREID=0, SKIP_X0=1). A queue-based reference model predicts the probe
// output, ready, overflow and drop count for every cycle.

module tb_difftest_int_wb_collector;

    localparam int DEPTH = 8;

    logic        io_clock;
    logic        io_reset;
    logic        io_in0_valid;
    logic [4:0]  io_in0_dest;
    logic [63:0] io_in0_data;
    logic        io_in1_valid;
    logic [4:0]  io_in1_dest;
    logic [63:0] io_in1_data;
    logic        io_in_ready;
    logic [7:0]  io_coreid;
    logic        io_valid;
    logic [31:0] io_dest;
    logic [63:0] io_data;
    logic        io_overflow;
    logic [15:0] io_drop_cnt;

    difftest_int_wb_collector dut (
        .io_clock     (io_clock),
        .io_reset     (io_reset),
        .io_in0_valid (io_in0_valid),
        .io_in0_dest  (io_in0_dest),
        .io_in0_data  (io_in0_data),
        .io_in1_valid (io_in1_valid),
        .io_in1_dest  (io_in1_dest),
        .io_in1_data  (io_in1_data),
        .io_in_ready  (io_in_ready),
        .io_coreid    (io_coreid),
        .io_valid     (io_valid),
        .io_dest      (io_dest),
        .io_data      (io_data),
        .io_overflow  (io_overflow),
        .io_drop_cnt  (io_drop_cnt)
    );

    initial io_clock = 1'b0;
    always #5 io_clock = ~io_clock;

    int checks;
    int failures;

    // reference model state
    logic [68:0] mq[$];
    logic        exp_valid;
    logic [31:0] exp_dest;
    logic [63:0] exp_data;
    logic        exp_ovf;
    int          exp_drop;
    logic        mdl_ready;
    logic        rdy_obs;

    task automatic model_reset();
        mq.delete();
        exp_valid = 1'b0;
        exp_dest  = '0;
        exp_data  = '0;
        exp_ovf   = 1'b0;
        exp_drop  = 0;
        mdl_ready = 1'b1;
    endtask

    // Drives one cycle of inputs (called at a negedge), advances the model
    // across the following rising edge and returns at the next negedge.
    task automatic step(input logic v0, input logic [4:0] d0, input logic [63:0] x0,
                        input logic v1, input logic [4:0] d1, input logic [63:0] x1);
        int old_size;
        logic [68:0] r;
        bit req0, req1;
        io_in0_valid = v0; io_in0_dest = d0; io_in0_data = x0;
        io_in1_valid = v1; io_in1_dest = d1; io_in1_data = x1;
        #1;
        rdy_obs  = io_in_ready;
        old_size = mq.size();
        mdl_ready = ((DEPTH - old_size) >= 2);
        req0 = v0 && (d0 != 5'd0);
        req1 = v1 && (d1 != 5'd0);
        if (old_size > 0) begin
            r = mq.pop_front();
            exp_valid = 1'b1;
            exp_dest  = {27'd0, r[68:64]};
            exp_data  = r[63:0];
        end else begin
            exp_valid = 1'b0;
        end
        if (mdl_ready) begin
            if (req0) mq.push_back({d0, x0});
            if (req1) mq.push_back({d1, x1});
        end else begin
            if (req0) begin exp_ovf = 1'b1; if (exp_drop < 16'hFFFF) exp_drop++; end
            if (req1) begin exp_ovf = 1'b1; if (exp_drop < 16'hFFFF) exp_drop++; end
        end
        @(posedge io_clock);
        @(negedge io_clock);
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    endtask

    task automatic apply_reset();
        io_reset = 1'b1;
        model_reset();
        @(posedge io_clock);
        @(posedge io_clock);
        @(negedge io_clock);
        io_reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (io_valid !== 1'b0 || io_dest !== 32'd0 || io_data !== 64'd0) begin
            failures++;
            $display("FAIL reset_out got v=%0b d=%0d x=%h exp v=0 d=0 x=0", io_valid, io_dest, io_data);
        end
        checks++;
        if (io_in_ready !== 1'b1 || io_overflow !== 1'b0 || io_drop_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_flags got rdy=%0b ovf=%0b drop=%0d exp rdy=1 ovf=0 drop=0",
                     io_in_ready, io_overflow, io_drop_cnt);
        end
        checks++;
        if (io_coreid !== 8'd0) begin
            failures++;
            $display("FAIL coreid got %0d exp 0", io_coreid);
        end
    endtask

    task automatic test_single();
        logic        ev[3];
        logic [31:0] ed[3];
        logic [63:0] ex[3];
        ev = '{1'b0, 1'b1, 1'b0};
        ed = '{32'd0, 32'd5, 32'd5};
        ex = '{64'd0, 64'hDEAD_BEEF, 64'hDEAD_BEEF};
        step(1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, 5'd0, 64'd0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) idle();
            checks++;
            if (io_valid !== ev[i] || io_dest !== ed[i] || io_data !== ex[i]) begin
                failures++;
                $display("FAIL single cyc=%0d got v=%0b d=%0d x=%h exp v=%0b d=%0d x=%h",
                         i + 1, io_valid, io_dest, io_data, ev[i], ed[i], ex[i]);
            end
        end
    endtask

    task automatic test_dual();
        logic        ev[4];
        logic [31:0] ed[4];
        logic [63:0] ex[4];
        ev = '{1'b1, 1'b1, 1'b1, 1'b0};
        ed = '{32'd1, 32'd2, 32'd3, 32'd3};
        ex = '{64'h11, 64'h22, 64'h33, 64'h33};
        step(1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22);
        step(1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 64'h33);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) idle();
            checks++;
            if (io_valid !== ev[i] || io_dest !== ed[i] || io_data !== ex[i]) begin
                failures++;
                $display("FAIL dual cyc=%0d got v=%0b d=%0d x=%h exp v=%0b d=%0d x=%h",
                         i + 2, io_valid, io_dest, io_data, ev[i], ed[i], ex[i]);
            end
        end
    endtask

    task automatic test_x0_filter();
        step(1'b1, 5'd0, 64'hFF, 1'b1, 5'd7, 64'h77);
        idle();
        checks++;
        if (io_valid !== 1'b1 || io_dest !== 32'd7 || io_data !== 64'h77) begin
            failures++;
            $display("FAIL x0_out got v=%0b d=%0d x=%h exp v=1 d=7 x=77", io_valid, io_dest, io_data);
        end
        idle();
        checks++;
        if (io_valid !== 1'b0 || io_drop_cnt !== 16'd0 || io_overflow !== 1'b0) begin
            failures++;
            $display("FAIL x0_after got v=%0b drop=%0d ovf=%0b exp v=0 drop=0 ovf=0",
                     io_valid, io_drop_cnt, io_overflow);
        end
    endtask

    // Generic per-cycle comparison against the model, repeated inline where needed.
    task automatic test_fill();
        for (int i = 0; i < 28; i++) begin
            if (i < 12)
                step(1'b1, 5'($urandom_range(1, 31)), {$urandom, $urandom},
                     1'b1, 5'($urandom_range(1, 31)), {$urandom, $urandom});
            else
                idle();
            checks++;
            if (io_valid !== exp_valid || io_dest !== exp_dest || io_data !== exp_data) begin
                failures++;
                $display("FAIL fill_out cyc=%0d got v=%0b d=%0d x=%h exp v=%0b d=%0d x=%h",
                         i, io_valid, io_dest, io_data, exp_valid, exp_dest, exp_data);
            end
            checks++;
            if (rdy_obs !== mdl_ready || io_overflow !== exp_ovf || io_drop_cnt !== 16'(exp_drop)) begin
                failures++;
                $display("FAIL fill_flags cyc=%0d got rdy=%0b ovf=%0b drop=%0d exp rdy=%0b ovf=%0b drop=%0d",
                         i, rdy_obs, io_overflow, io_drop_cnt, mdl_ready, exp_ovf, exp_drop);
            end
        end
        // 12 dual cycles from empty: ready alternates once count hits 7, three cycles drop 2 each
        checks++;
        if (io_overflow !== 1'b1 || io_drop_cnt !== 16'd6) begin
            failures++;
            $display("FAIL fill_drops got ovf=%0b drop=%0d exp ovf=1 drop=6", io_overflow, io_drop_cnt);
        end
    endtask

    task automatic test_half_rate();
        logic [15:0] drop0;
        drop0 = io_drop_cnt;
        for (int i = 0; i < 100; i++) begin
            if (i % 2 == 0)
                step(1'b1, 5'($urandom_range(1, 31)), {$urandom, $urandom},
                     1'b1, 5'($urandom_range(1, 31)), {$urandom, $urandom});
            else
                idle();
            checks++;
            if (io_valid !== exp_valid || io_dest !== exp_dest || io_data !== exp_data) begin
                failures++;
                $display("FAIL half_out cyc=%0d got v=%0b d=%0d x=%h exp v=%0b d=%0d x=%h",
                         i, io_valid, io_dest, io_data, exp_valid, exp_dest, exp_data);
            end
            if (i >= 1) begin
                checks++;
                if (io_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL half_cont cyc=%0d got v=%0b exp v=1", i, io_valid);
                end
            end
        end
        repeat (3) idle();
        checks++;
        if (io_drop_cnt !== drop0 || io_valid !== 1'b0) begin
            failures++;
            $display("FAIL half_drops got drop=%0d v=%0b exp drop=%0d v=0", io_drop_cnt, io_valid, drop0);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 170; i++) begin
            if (i < 150)
                step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), {$urandom, $urandom},
                     1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), {$urandom, $urandom});
            else
                idle();
            checks++;
            if (io_valid !== exp_valid || io_dest !== exp_dest || io_data !== exp_data) begin
                failures++;
                $display("FAIL b2b_out cyc=%0d got v=%0b d=%0d x=%h exp v=%0b d=%0d x=%h",
                         i, io_valid, io_dest, io_data, exp_valid, exp_dest, exp_data);
            end
            checks++;
            if (rdy_obs !== mdl_ready || io_overflow !== exp_ovf || io_drop_cnt !== 16'(exp_drop)) begin
                failures++;
                $display("FAIL b2b_flags cyc=%0d got rdy=%0b ovf=%0b drop=%0d exp rdy=%0b ovf=%0b drop=%0d",
                         i, rdy_obs, io_overflow, io_drop_cnt, mdl_ready, exp_ovf, exp_drop);
            end
        end
    endtask

    task automatic test_reset_mid();
        repeat (4) step(1'b1, 5'($urandom_range(1, 31)), {$urandom, $urandom},
                        1'b1, 5'($urandom_range(1, 31)), {$urandom, $urandom});
        checks++;
        if (io_valid !== 1'b1) begin
            failures++;
            $display("FAIL rmid_pre got v=%0b exp v=1 (buffered=%0d)", io_valid, mq.size());
        end
        io_reset = 1'b1;
        #1;
        checks++;
        if (io_valid !== 1'b0) begin
            failures++;
            $display("FAIL rmid_async got v=%0b exp v=0", io_valid);
        end
        model_reset();
        @(posedge io_clock);
        @(negedge io_clock);
        io_reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idle();
            checks++;
            if (io_valid !== 1'b0 || io_dest !== 32'd0 || io_data !== 64'd0 ||
                io_overflow !== 1'b0 || io_drop_cnt !== 16'd0 || rdy_obs !== 1'b1) begin
                failures++;
                $display("FAIL rmid_stale cyc=%0d got v=%0b d=%0d x=%h ovf=%0b drop=%0d rdy=%0b exp all zero, rdy=1",
                         i, io_valid, io_dest, io_data, io_overflow, io_drop_cnt, rdy_obs);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        io_reset = 1'b1;
        io_in0_valid = 1'b0; io_in0_dest = '0; io_in0_data = '0;
        io_in1_valid = 1'b0; io_in1_dest = '0; io_in1_data = '0;
        model_reset();
        @(negedge io_clock);
        test_reset();
        test_single();
        test_dual();
        test_x0_filter();
        test_fill();
        test_half_rate();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
